// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the two-requester memory arbiter.
//   Holds the bus widths, requester count, FSM state type, the latched
//   request record and a one-hot to index helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int NUM_REQ = 2;

  // Width of a requester index; kept at least 1 so single-requester builds
  // still have a usable index type.
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Everything about a request that must survive after req drops.
  typedef struct packed {
    logic              we;
    logic              ind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Converts a one-hot grant vector into the index of its set bit.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// ---------------------------------------------------------------------------
// mem_arb_rr
//   Round-robin pick logic. Starting from the requester after the one
//   granted last, the first active request wins. Purely combinational.
//
//   Ports:
//     req       in  NUM_REQ  active request lines
//     last_gnt  in  IDX_W    index of the requester served most recently
//     grant     out NUM_REQ  one-hot winner (all zero when no request)
// ---------------------------------------------------------------------------
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [NUM_REQ-1:0] grant
);

  // Walk the requesters in rotated order, beginning one past last_gnt, so
  // the most recently served requester has the lowest priority.
  always_comb begin : pick
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_gnt) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req[idx[IDX_W-1:0]]) begin
        grant[idx[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a single memory port between requester 0 (CPU data path) and
//   requester 1 (loader/debug port). One transaction at a time:
//   IDLE -> [PTR] -> ACCESS -> RESP -> IDLE.
//
//   Indirect accesses read a 12-bit pointer from the given address and then
//   access the word it points to. By default this is done here with an
//   extra PTR cycle. Defining MEM_ARB_NATIVE_INDIRECT_EN hands indirection
//   to the memory through doubleRead/doubleWrite and skips PTR.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     reqN/weN/indN             request, write, indirect (N = 0, 1)
//     addrN [11:0]              byte address (bit 0 passed through as-is)
//     wdataN [15:0]             write data
//     gntN                      held from the cycle after pick until RESP
//     doneN                     one-cycle completion pulse
//     rdataN [15:0]             last read data for that requester
//     address_bus [11:0]        memory address
//     data_bus [15:0]           memory read data
//     incoming_data_bus [15:0]  memory write data
//     write_mode                memory write strobe
//     doubleRead/doubleWrite    native indirect controls (0 unless macro)
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              we0,
  input  logic              ind0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic              ind1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,

  output logic [ADDR_W-1:0] address_bus,
  input  logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] incoming_data_bus,
  output logic              write_mode,
  output logic              doubleRead,
  output logic              doubleWrite
);

  state_t              state;
  state_t              next_state;

  logic [NUM_REQ-1:0]  req_vec;
  logic [NUM_REQ-1:0]  pick;
  logic                any_req;
  req_t                sel_req;

  req_t                cur_q;
  logic [IDX_W-1:0]    cur_id_q;
  logic [IDX_W-1:0]    last_gnt_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [DATA_W-1:0]   rdata_q [NUM_REQ];

  logic                split_sel;
  logic                split_cur;
  logic                write_mode_raw;
  logic                double_read_raw;
  logic                double_write_raw;

  assign req_vec = {req1, req0};
  assign any_req = |req_vec;

  mem_arb_rr u_rr (
    .req      (req_vec),
    .last_gnt (last_gnt_q),
    .grant    (pick)
  );

  // Request fields of whichever requester the round-robin picked this cycle.
  always_comb begin
    sel_req = {we0, ind0, addr0, wdata0};
    if (pick[1]) begin
      sel_req = {we1, ind1, addr1, wdata1};
    end
  end

  // Whether an indirect request needs the local pointer fetch. With native
  // indirection the memory dereferences, so nothing is ever split here.
`ifdef MEM_ARB_NATIVE_INDIRECT_EN
  assign split_sel = 1'b0;
  assign split_cur = 1'b0;
`else
  assign split_sel = sel_req.ind;
  assign split_cur = cur_q.ind;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and memory-side outputs. All memory outputs idle at zero
  // except in PTR and ACCESS.
  always_comb begin
    next_state        = state;
    address_bus       = '0;
    incoming_data_bus = '0;
    write_mode_raw    = 1'b0;
    double_read_raw   = 1'b0;
    double_write_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = split_sel ? PTR : ACCESS;
        end
      end
      PTR: begin
        address_bus = cur_q.addr;
        next_state  = ACCESS;
      end
      ACCESS: begin
        address_bus       = split_cur ? ptr_q : cur_q.addr;
        write_mode_raw    = cur_q.we;
        incoming_data_bus = cur_q.wdata;
`ifdef MEM_ARB_NATIVE_INDIRECT_EN
        double_read_raw   = cur_q.ind & ~cur_q.we;
        double_write_raw  = cur_q.ind &  cur_q.we;
`endif
        next_state        = RESP;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The write strobes are masked by reset combinationally so a reset
  // landing on an ACCESS cycle can never commit a write on that edge.
  assign write_mode  = write_mode_raw & ~rst;
  assign doubleWrite = double_write_raw & ~rst;
  assign doubleRead  = double_read_raw;

  // Transaction datapath: latch the request on pick, grab the pointer in
  // PTR, capture read data in ACCESS and pulse done while in RESP. last_gnt
  // resets to the highest index so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q      <= '0;
      cur_id_q   <= '0;
      last_gnt_q <= IDX_W'(NUM_REQ - 1);
      ptr_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cur_q    <= sel_req;
            cur_id_q <= onehot_to_idx(pick);
            gnt_q    <= pick;
          end
        end
        PTR: begin
          ptr_q <= data_bus[ADDR_W-1:0];
        end
        ACCESS: begin
          if (!cur_q.we) begin
            rdata_q[cur_id_q] <= data_bus;
          end
          gnt_q            <= '0;
          done_q[cur_id_q] <= 1'b1;
        end
        RESP: begin
          last_gnt_q <= cur_id_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt0   = gnt_q[0];
  assign gnt1   = gnt_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter with a behavioural 4K x 16 memory.
//   Honours MEM_ARB_NATIVE_INDIRECT_EN for the expected indirect latency.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_NATIVE_INDIRECT_EN
  localparam int IND_LAT = 2;
`else
  localparam int IND_LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        req0, we0, ind0;
  logic [11:0] addr0;
  logic [15:0] wdata0;
  logic        gnt0, done0;
  logic [15:0] rdata0;
  logic        req1, we1, ind1;
  logic [11:0] addr1;
  logic [15:0] wdata1;
  logic        gnt1, done1;
  logic [15:0] rdata1;
  logic [11:0] address_bus;
  logic [15:0] data_bus;
  logic [15:0] incoming_data_bus;
  logic        write_mode, doubleRead, doubleWrite;

  mem_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .req0              (req0),
    .we0               (we0),
    .ind0              (ind0),
    .addr0             (addr0),
    .wdata0            (wdata0),
    .gnt0              (gnt0),
    .done0             (done0),
    .rdata0            (rdata0),
    .req1              (req1),
    .we1               (we1),
    .ind1              (ind1),
    .addr1             (addr1),
    .wdata1            (wdata1),
    .gnt1              (gnt1),
    .done1             (done1),
    .rdata1            (rdata1),
    .address_bus       (address_bus),
    .data_bus          (data_bus),
    .incoming_data_bus (incoming_data_bus),
    .write_mode        (write_mode),
    .doubleRead        (doubleRead),
    .doubleWrite       (doubleWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: asynchronous read, write on the clock edge. The
  // double* controls make the memory dereference a stored pointer itself.
  logic [15:0] mem [4096];
  logic        preload;
  logic [15:0] mem_first;

  assign mem_first = mem[address_bus];
  assign data_bus  = doubleRead ? mem[mem_first[11:0]] : mem_first;

  always @(posedge clk) begin
    if (preload) begin
      mem[12'h412] <= 16'h0018;
      mem[12'h413] <= 16'h00A5;
      mem[12'h460] <= 16'h0500;
      mem[12'h500] <= 16'hBBBB;
    end else if (write_mode) begin
      if (doubleWrite) begin
        mem[mem_first[11:0]] <= incoming_data_bus;
      end else begin
        mem[address_bus] <= incoming_data_bus;
      end
    end
  end

  typedef struct {
    string       name;
    int          id;
    logic        we;
    logic        ind;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] rdata;
  } exp_t;

  vec_t vecs [8];
  exp_t expQ [$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mkVec(input string n, input int id, input logic we, input logic ind,
                                 input logic [11:0] a, input logic [15:0] wd,
                                 input logic [15:0] er, input int el);
    vec_t v;
    v.name = n;  v.id = id;  v.we = we;  v.ind = ind;
    v.addr = a;  v.wdata = wd;  v.exp_rdata = er;  v.exp_lat = el;
    return v;
  endfunction

  function automatic logic getDone(input int id);
    return (id == 1) ? done1 : done0;
  endfunction

  function automatic logic getGnt(input int id);
    return (id == 1) ? gnt1 : gnt0;
  endfunction

  function automatic logic [15:0] getRdata(input int id);
    return (id == 1) ? rdata1 : rdata0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: no done within cycle budget", name);
  endtask

  task automatic driveReq(input int id, input logic r, input logic we, input logic ind,
                          input logic [11:0] a, input logic [15:0] wd);
    if (id == 1) begin
      req1 = r;  we1 = we;  ind1 = ind;  addr1 = a;  wdata1 = wd;
    end else begin
      req0 = r;  we0 = we;  ind0 = ind;  addr0 = a;  wdata0 = wd;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated transaction from IDLE: drive at a falling edge, track
  // latency in rising edges, compare against the scoreboard on done.
  task automatic applyStimulus(input vec_t v);
    int   lat;
    exp_t e;
    driveReq(v.id, 1'b1, v.we, v.ind, v.addr, v.wdata);
    expQ.push_back('{id: v.id, rdata: v.exp_rdata});
    nextCycle();
    lat = 1;
    checkOutput({v.name, "_gnt_held"}, 32'(getGnt(v.id)), 32'd1);
    while (!getDone(v.id) && lat < 20) begin
      nextCycle();
      lat++;
    end
    if (!getDone(v.id)) begin
      failNow({v.name, "_timeout"});
      expQ.delete();
      driveReq(v.id, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
      return;
    end
    e = expQ.pop_front();
    checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({v.name, "_rdata"}, 32'(getRdata(e.id)), 32'(e.rdata));
    checkOutput({v.name, "_gnt_dropped"}, 32'(getGnt(v.id)), 32'd0);
    checkOutput({v.name, "_other_done"}, 32'(getDone(1 - v.id)), 32'd0);
    driveReq(v.id, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    nextCycle();
    checkOutput({v.name, "_done_pulse"}, 32'(getDone(v.id)), 32'd0);
    checkOutput({v.name, "_idle_addr"}, 32'(address_bus), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   cyc;
    int   seen0;
    int   seen1;
    int   lat;
    logic extra;
    exp_t e;

    // Reads and writes are ordered so every rdata change is visible:
    // a write must leave rdata at the value from that requester's last read.
    vecs[0] = mkVec("rd_direct",    0, 1'b0, 1'b0, 12'h412, 16'h0000, 16'h0018, 2);
    vecs[1] = mkVec("rd_indirect",  1, 1'b0, 1'b1, 12'h460, 16'h0000, 16'hBBBB, IND_LAT);
    vecs[2] = mkVec("wr_direct",    0, 1'b1, 1'b0, 12'h412, 16'h1234, 16'h0018, 2);
    vecs[3] = mkVec("rd_after_wr",  0, 1'b0, 1'b0, 12'h412, 16'h0000, 16'h1234, 2);
    vecs[4] = mkVec("rd_odd_addr",  1, 1'b0, 1'b0, 12'h413, 16'h0000, 16'h00A5, 2);
    vecs[5] = mkVec("wr_indirect",  1, 1'b1, 1'b1, 12'h460, 16'hCAFE, 16'h00A5, IND_LAT);
    vecs[6] = mkVec("rd_target",    1, 1'b0, 1'b0, 12'h500, 16'h0000, 16'hCAFE, 2);
    vecs[7] = mkVec("rd_ind_req0",  0, 1'b0, 1'b1, 12'h460, 16'h0000, 16'hCAFE, IND_LAT);

    rst     = 1'b1;
    preload = 1'b1;
    driveReq(0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    driveReq(1, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    preload = 1'b0;

    checkOutput("rst_gnt",     32'({gnt1, gnt0}), 32'd0);
    checkOutput("rst_done",    32'({done1, done0}), 32'd0);
    checkOutput("rst_rdata0",  32'(rdata0), 32'd0);
    checkOutput("rst_rdata1",  32'(rdata1), 32'd0);
    checkOutput("rst_addr",    32'(address_bus), 32'd0);
    checkOutput("rst_wdata",   32'(incoming_data_bus), 32'd0);
    checkOutput("rst_ctrl",    32'({write_mode, doubleRead, doubleWrite}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Simultaneous requests straight out of reset: 0 first, 1 three later.
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    driveReq(0, 1'b1, 1'b0, 1'b0, 12'h412, 16'h0);
    driveReq(1, 1'b1, 1'b0, 1'b0, 12'h413, 16'h0);
    expQ.push_back('{id: 0, rdata: 16'h1234});
    expQ.push_back('{id: 1, rdata: 16'h00A5});
    cyc   = 0;
    seen0 = -1;
    seen1 = -1;
    while ((seen0 < 0 || seen1 < 0) && cyc < 20) begin
      nextCycle();
      cyc++;
      if (cyc == 1) begin
        checkOutput("tie_first_gnt", 32'({gnt1, gnt0}), 32'd1);
      end
      if (done0 || done1) begin
        if (expQ.size() == 0) begin
          failNow("tie_extra_done");
        end else begin
          e = expQ.pop_front();
          checkOutput("tie_order", 32'(done1 ? 1 : 0), 32'(e.id));
          checkOutput("tie_rdata", 32'(getRdata(e.id)), 32'(e.rdata));
        end
        if (done0) begin
          seen0 = cyc;
          driveReq(0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
        end
        if (done1) begin
          seen1 = cyc;
          driveReq(1, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
        end
      end
    end
    if (seen0 < 0 || seen1 < 0) begin
      failNow("tie_timeout");
      driveReq(0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
      driveReq(1, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    end else begin
      checkOutput("tie_done0_lat", 32'(seen0), 32'd2);
      checkOutput("tie_gap", 32'(seen1 - seen0), 32'd3);
    end
    expQ.delete();
    nextCycle();

    // Reset landing on the ACCESS cycle of a write must suppress it.
    driveReq(0, 1'b1, 1'b1, 1'b0, 12'h412, 16'h5555);
    nextCycle();
    checkOutput("rstw_we_before", 32'(write_mode), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstw_we_gated", 32'(write_mode), 32'd0);
    nextCycle();
    checkOutput("rstw_mem_kept", 32'(mem[12'h412]), 32'h1234);
    checkOutput("rstw_gnt",      32'({gnt1, gnt0}), 32'd0);
    checkOutput("rstw_done",     32'({done1, done0}), 32'd0);
    checkOutput("rstw_rdata",    32'({rdata1, rdata0}), 32'd0);
    checkOutput("rstw_addr",     32'(address_bus), 32'd0);
    rst = 1'b0;
    driveReq(0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    nextCycle();

    // req0 withdrawn mid-transaction: it still completes, exactly once.
    driveReq(0, 1'b1, 1'b0, 1'b0, 12'h412, 16'h0);
    nextCycle();
    checkOutput("drop_gnt", 32'(gnt0), 32'd1);
    driveReq(0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
    lat = 1;
    while (!done0 && lat < 20) begin
      nextCycle();
      lat++;
    end
    if (!done0) begin
      failNow("drop_timeout");
    end else begin
      checkOutput("drop_latency", 32'(lat), 32'd2);
      checkOutput("drop_rdata", 32'(rdata0), 32'h1234);
    end
    extra = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      extra = extra | gnt0 | done0;
    end
    checkOutput("drop_no_regrant", 32'(extra), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high, on ports clk and rst.
REQ-002 Ports SHALL be: clk in 1 system clock; rst in 1 sync active-high reset.
REQ-003 Per requester N in {0,1}, ports SHALL be: reqN in 1 request; weN in 1 write; indN in 1 indirect; addrN in 12 byte address; wdataN in 16 write data; gntN out 1 grant held; doneN out 1 one-cycle completion; rdataN out 16 read data.
REQ-004 Memory-side ports SHALL be: address_bus out 12; data_bus in 16 read data; incoming_data_bus out 16; write_mode out 1; doubleRead out 1; doubleWrite out 1.
REQ-005 Requester 0 is the CPU data path and requester 1 is the loader/debug port; the instruction port is outside this block.

Function
REQ-006 FSM states SHALL be IDLE, PTR, ACCESS, RESP.
REQ-007 IDLE: if any reqN is high, arbiter picks one, latches we/ind/addr/wdata, asserts gntN from the next cycle, goes to PTR if indirect-split applies, else ACCESS.
REQ-008 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-009 PTR: drive address_bus=latched addr, write_mode=0; capture data_bus[11:0] as pointer; go to ACCESS.
REQ-010 ACCESS: address_bus = pointer (split indirect) or latched addr; write_mode=we; incoming_data_bus=wdata; capture data_bus into rdata register on reads; go to RESP.
REQ-011 RESP: pulse doneN for exactly one cycle with rdataN valid; drop gntN in the same cycle; record last-granted; go to IDLE.
REQ-012 Latency from req sampled in IDLE to doneN SHALL be 2 cycles direct, 3 cycles split indirect.
REQ-013 Outside PTR/ACCESS, address_bus=0, incoming_data_bus=0, write_mode=0, doubleRead=0, doubleWrite=0.
REQ-014 reqN falling mid-transaction SHALL be ignored; the transaction completes.
REQ-015 A requester still asserting req in the IDLE after its done SHALL be treated as a new request.
REQ-016 rdataN SHALL hold its last value until that requester's next read completes; writes SHALL NOT update rdataN.
REQ-017 Address bit 0 SHALL pass through unchanged; no alignment checks.

Reset
REQ-018 On rst: state=IDLE, gnt0/1=0, done0/1=0, rdata0/1=0, pointer=0, last-granted=1.
REQ-019 write_mode SHALL be gated by !rst combinationally so no write commits on a reset edge, including mid-ACCESS.

Configuration
REQ-020 Macro MEM_ARB_NATIVE_INDIRECT_EN defined: indirect accesses skip PTR and use doubleRead=ind&~we / doubleWrite=ind&we in ACCESS (2-cycle latency).
REQ-021 Macro undefined: doubleRead/doubleWrite are tied 0 and indirect accesses use PTR then a direct ACCESS (3-cycle latency).

Structure
REQ-022 Package mem_arb_pkg SHALL hold: ADDR_W=12, DATA_W=16, NUM_REQ=2, state enum type, request struct (we, ind, addr, wdata).
REQ-023 Round-robin pick logic SHALL be the sub-module mem_arb_rr (req vector, last-granted in; one-hot grant out).

Verification
REQ-024 Direct read: req0, addr0=0x412, we0=0 -> done0 two cycles later, rdata0=0x0018.
REQ-025 Indirect read: req1, ind1=1, addr1=0x460 -> rdata1=0xBBBB, latency 3 (split) or 2 (macro defined).
REQ-026 Tie: req0 and req1 both high from reset, both direct reads -> requester 0 served first, requester 1 done 3 cycles after done0.
REQ-027 Write then read: req0 we0=1 addr0=0x412 wdata0=0x1234, then read 0x412 -> rdata0=0x1234; rdata0 unchanged by the write.
REQ-028 rst asserted during ACCESS of a write to 0x412 (0x5555) -> memory word keeps prior value, all outputs at reset values next cycle.
REQ-029 req0 dropped during ACCESS -> done0 still pulses once; FSM returns to IDLE with no second grant.
